// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies and the FSM state type.
package mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {IDLE, RUN} mdu_state_t;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational mult/multu/div/divu result generator; all sign handling and
// divide corner cases are resolved here so the sequencer only moves values.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic        [WIDTH-1:0]   b_safe, abs_a, abs_b, q_u, r_u, q_mag, r_mag;

  assign prod_s = $signed(a) * $signed(b);
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Divisor forced to 1 on zero so the dividers never see /0; results are discarded then.
  assign div_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == '0);
  assign b_safe   = (b == '0) ? WIDTH'(1) : b;

  assign q_u = a / b_safe;
  assign r_u = a % b_safe;

  // Signed divide on magnitudes: most-negative / -1 wraps back to most-negative, remainder 0.
  assign abs_a = magnitude(a);
  assign abs_b = magnitude(b_safe);
  assign q_mag = abs_a / abs_b;
  assign r_mag = abs_a % abs_b;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MDU_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      MDU_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      MDU_DIV: begin
        res_hi = cond_neg(r_mag, a[WIDTH-1]);
        res_lo = cond_neg(q_mag, a[WIDTH-1] ^ b_safe[WIDTH-1]);
      end
      MDU_DIVU: begin
        res_hi = r_u;
        res_lo = q_u;
      end
      MDU_NONE: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide sequencer: latches the result at acceptance, holds
// busy for the op latency, then commits HI/LO in one edge.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             div_zero, is_div, accept_md;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op       (op),
    .a        (a),
    .b        (b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  // A new mult/div may also start on the commit edge, giving zero idle cycles between ops.
  assign accept_md = start && is_muldiv(op) && ((state_q == IDLE) || (cnt_q == '0));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start && (op == MDU_MTHI)) hi_d = a;
        if (start && (op == MDU_MTLO)) lo_d = a;
      end
      RUN: begin
        if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept_md) begin
      state_d   = RUN;
      cnt_d     = is_div ? DIV_LOAD : MULT_LOAD;
      // Divide by zero commits the values HI/LO already hold.
      pend_hi_d = div_zero ? hi_d : res_hi;
      pend_lo_d = div_zero ? lo_d : res_lo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: arithmetic results, latency, mthi/mtlo,
// divide-by-zero, back-to-back issue and asynchronous reset.
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  e_mdu #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = MDU_NONE;
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input int n,
                        input logic [W-1:0] old_hi, input logic [W-1:0] old_lo,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    issue(o, va, vb);
    check({tag, ".busy_acc"}, W'(busy), 1);
    check({tag, ".hi_acc"}, hi, old_hi);
    check({tag, ".lo_acc"}, lo, old_lo);
    repeat (n - 1) begin
      @(posedge clk);
      #1;
      check({tag, ".busy_run"}, W'(busy), 1);
      check({tag, ".hi_run"}, hi, old_hi);
      check({tag, ".lo_run"}, lo, old_lo);
    end
    @(posedge clk);
    #1;
    check({tag, ".busy_done"}, W'(busy), 0);
    check({tag, ".hi"}, hi, exp_hi);
    check({tag, ".lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = MDU_NONE;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", W'(busy), 0);
    check("rst.hi", hi, 0);
    check("rst.lo", lo, 0);
    @(negedge clk);
    reset = 1'b1;

    run_md("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10,
           32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divmin", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0, 32'h8000_0000);

    issue(MDU_MTHI, 32'h1234, 32'h0);
    check("mthi.busy", W'(busy), 0);
    check("mthi.hi", hi, 32'h1234);
    check("mthi.lo", lo, 32'h8000_0000);
    issue(MDU_MTLO, 32'h5678, 32'h0);
    check("mtlo.busy", W'(busy), 0);
    check("mtlo.hi", hi, 32'h1234);
    check("mtlo.lo", lo, 32'h5678);
    issue(3'd7, 32'h9999, 32'h1);
    check("op7.busy", W'(busy), 0);
    check("op7.hi", hi, 32'h1234);
    check("op7.lo", lo, 32'h5678);

    run_md("divu0", MDU_DIVU, 32'd42, 32'd0, 10, 32'h1234, 32'h5678, 32'h1234, 32'h5678);

    // mult 3*4, mtlo attempted mid-run, multu issued on the commit edge
    issue(MDU_MULT, 32'd3, 32'd4);
    check("b2b.busy_acc", W'(busy), 1);
    @(negedge clk);
    start = 1'b1;
    op    = MDU_MTLO;
    a     = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = MDU_NONE;
    check("ign.lo", lo, 32'h5678);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("ign.busy", W'(busy), 1);
      check("ign.lo_run", lo, 32'h5678);
    end
    @(negedge clk);
    start = 1'b1;
    op    = MDU_MULTU;
    a     = 32'h0001_0000;
    b     = 32'h0001_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = MDU_NONE;
    check("b2b.busy_edge", W'(busy), 1);
    check("b2b.hi1", hi, 32'h0);
    check("b2b.lo1", lo, 32'hC);
    repeat (4) begin
      @(posedge clk);
      #1;
      check("b2b.busy_run", W'(busy), 1);
      check("b2b.lo_run", lo, 32'hC);
    end
    @(posedge clk);
    #1;
    check("b2b.busy_done", W'(busy), 0);
    check("b2b.hi2", hi, 32'h1);
    check("b2b.lo2", lo, 32'h0);

    // asynchronous reset in the middle of a divide
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst.busy", W'(busy), 0);
    check("arst.hi", hi, 0);
    check("arst.lo", lo, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      check("post.busy", W'(busy), 0);
      check("post.hi", hi, 0);
      check("post.lo", lo, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the E stage of the five-stage pipeline. It accepts one operation per start pulse and holds `busy` for a configurable number of cycles. It then commits HI/LO atomically. The stall unit uses `busy` and `start` to hold mult/div/mfhi/mflo/mthi/mtlo in D while the unit is occupied.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be at least 2.
- `MULT_CYCLES`, 5: busy duration for mult/multu; must be at least 1.
- `DIV_CYCLES`, 10: busy duration for div/divu; must be at least 1.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately.
- `start`  in  1  launch the operation in `op` this cycle.
- `op`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is treated as none.
- `a`  in  WIDTH  forwarded rs value (E_FW_Rs).
- `b`  in  WIDTH  forwarded rt value (E_FW_Rt).
- `busy`  out  1  a multiply or divide is in progress.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **Reset.** While `reset` is 0:
  - `busy`, `hi`, `lo`, the counter and the pending registers are all 0.
  - Any in-flight operation is discarded.
- **States.**
  - IDLE (busy=0) and RUN (busy=1).
  - The cycle counter is `$clog2(max(MULT_CYCLES, DIV_CYCLES)+1)` bits wide.
- **IDLE, start with op 1–4:**
  - The result is computed from `a`/`b` at the accepting edge and latched into pending_hi/pending_lo.
  - The counter is loaded with N−1, where N is MULT_CYCLES or DIV_CYCLES.
  - The unit goes to RUN.
- **IDLE, start with op 5/6:** `hi` (op 5) or `lo` (op 6) takes `a` at the accepting edge; the unit stays in IDLE.
- **IDLE, start with op 0/7, or `start`=0:** no change.
- **RUN:**
  - The counter decrements each edge.
  - On the edge where the counter is 0, `hi`/`lo` take the pending values and the unit returns to IDLE.
  - `start` is ignored in RUN, for every op. The stall unit guarantees it is not asserted there.
- **Arithmetic:**
  - **mult:** signed WIDTH×WIDTH product; `hi` = upper WIDTH bits, `lo` = lower WIDTH bits.
  - **multu:** as mult, unsigned.
  - **div:** signed; `lo` = quotient truncated toward zero, `hi` = remainder with the sign of the dividend.
    - Most-negative ÷ −1: `lo` = most-negative, `hi` = 0.
  - **divu:** unsigned quotient and remainder.
  - **Divide by zero (div or divu):** the full busy duration is still spent, and `hi`/`lo` are left unchanged.
- **Combined stall term:** the stall unit must stall D for any md/mf/mt instruction when `busy` is 1, or when `start` is 1 with op 1–4.

## Timing
- Start accepted at edge t:
  - `busy` is 1 from edge t through edge t+N.
  - `hi`/`lo` change at edge t+N.
  - `busy` falls at the same edge, t+N.
  - So `busy` is high for exactly N cycles.
- With N=1, `busy` is high for one cycle, and the results appear one edge after acceptance.
- A new start may be accepted at the same edge where `busy` falls, i.e. back-to-back operations separated by 0 idle cycles.
- mthi/mtlo: the new value is visible on the cycle after the accepting edge; no busy cycle.
- `hi`/`lo` never show partial results. They always show either the previous committed value or the new one.
- Asynchronous reset assertion mid-RUN takes effect immediately. After deassertion the unit is in IDLE with `hi` = `lo` = 0.

## Structure
- Package `mdu_pkg` holds:
  - op encodings `MDU_NONE`…`MDU_MTLO` (3-bit localparams);
  - the default latency constants;
  - a `mdu_state_t` enum {IDLE, RUN}.
- Sub-module `mdu_calc`: purely combinational. It takes `a`, `b`, `op` and produces `res_hi`, `res_lo`, `div_zero`. All signed/unsigned and corner-case arithmetic lives there.
- `e_mdu` holds only the FSM, the counter, the pending registers and HI/LO.

## Test plan
- **mult:**
  - Stimulus: reset, then start mult with a=0xFFFFFFFE (−2), b=3.
  - Required: busy is high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Also required: hi/lo stay 0 during busy.
- **multu:**
  - Stimulus: start multu with a=0xFFFFFFFF, b=0xFFFFFFFF.
  - Required: after 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- **div:**
  - Stimulus: start div with a=−7, b=2.
  - Required: after 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Stimulus: then start div with a=0x80000000, b=0xFFFFFFFF.
  - Required: lo=0x80000000, hi=0.
- **Divide by zero and mthi/mtlo:**
  - Stimulus: mthi a=0x1234; mtlo a=0x5678.
  - Required: hi=0x1234 and lo=0x5678, each on the next cycle, with busy=0.
  - Stimulus: then divu with b=0.
  - Required: busy is high for 10 cycles, and hi/lo remain 0x1234/0x5678.
- **Back-to-back and ignore rule:**
  - Stimulus: start mult, then assert start with mtlo during busy.
  - Required: the mtlo is ignored.
  - Stimulus: start multu at the edge where busy falls.
  - Required: it is accepted, and busy stays high continuously.
- **Reset mid-operation:**
  - Stimulus: pull `reset` low 3 cycles into a div.
  - Required: busy, hi and lo go to 0 without waiting for a clock edge.
  - Required: after release, no commit ever occurs.
